// File: rtl/if_fetch_pkg.sv
// Shared fetch-path constants for the single-issue core front end.
package if_fetch_pkg;

  localparam int unsigned     AddrLen  = 32;
  localparam int unsigned     InstLen  = 32;
  localparam logic [31:0]     ZeroWord = '0;
  localparam logic [31:0]     PcStep   = 32'd4;
  localparam logic [31:0]     ResetPc  = ZeroWord;

endpackage

// File: rtl/if_fetch_queue.sv
// fetch_queue: small synchronous FIFO of {pc, inst} pairs between fetch and decode.
module fetch_queue #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [PC_W-1:0]              push_pc_i,
  input  logic [INST_W-1:0]            push_inst_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic [PC_W-1:0]              head_pc_o,
  output logic [INST_W-1:0]            head_inst_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PC_W-1:0]   pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full_o      = (count_q == CntW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign head_pc_o   = pc_mem_q[rd_ptr_q];
  assign head_inst_o = inst_mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Flush overrides a same-cycle pop; the popped word has already left via the head outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        pc_mem_q[wr_ptr_q]   <= push_pc_i;
        inst_mem_q[wr_ptr_q] <= push_inst_i;
        wr_ptr_q             <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: PC register, ROM drive, redirect handling and fetch queue.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned          ADDR_LEN    = AddrLen,
  parameter int unsigned          INST_LEN    = InstLen,
  parameter logic [ADDR_LEN-1:0]  RESET_PC    = ADDR_LEN'(ResetPc),
  parameter int unsigned          QUEUE_DEPTH = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  output logic [ADDR_LEN-1:0] rom_addr_o,
  output logic                rom_ce_o,
  input  logic [INST_LEN-1:0] rom_data_i,
  input  logic                branch_i,
  input  logic [ADDR_LEN-1:0] branch_addr_i,
  output logic                if_valid_o,
  input  logic                if_ready_i,
  output logic [INST_LEN-1:0] if_inst_o,
  output logic [ADDR_LEN-1:0] if_pc_o
);

  localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1;

  logic [ADDR_LEN-1:0] pc_q, pc_d;
  logic                q_full, q_empty;
  logic [CntW-1:0]     q_count;
  logic                pop, fetch;

  assign pop        = if_valid_o && if_ready_i;
  assign fetch      = rst_in && !branch_i && (!q_full || pop);
  assign rom_ce_o   = fetch;
  assign rom_addr_o = pc_q;
  assign if_valid_o = !q_empty;

  always_comb begin
    pc_d = pc_q;
    if (branch_i) begin
      pc_d = {branch_addr_i[ADDR_LEN-1:2], 2'b00};
    end else if (fetch) begin
      pc_d = pc_q + ADDR_LEN'(PcStep);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue #(
    .PC_W   (ADDR_LEN),
    .INST_W (INST_LEN),
    .DEPTH  (QUEUE_DEPTH)
  ) u_queue (
    .clk_i       (clk_in),
    .rst_ni      (rst_in),
    .push_i      (fetch),
    .pop_i       (pop),
    .flush_i     (branch_i),
    .push_pc_i   (pc_q),
    .push_inst_i (rom_data_i),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count),
    .head_pc_o   (if_pc_o),
    .head_inst_o (if_inst_o)
  );

  a_full_count : assert property (@(posedge clk_in) disable iff (!rst_in)
    q_full == (q_count == CntW'(QUEUE_DEPTH)));

endmodule
